// File: rtl/tx_pkg.sv
// Shared types and constants for the transmit frame sequencer.
package tx_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PREAMBLE = 2'd1,
      PAYLOAD  = 2'd2,
      FLUSH    = 2'd3
   } tx_state_t;

   localparam int TX_DATA_WIDTH = 16;
   localparam int TX_UPSAMPLE   = 6;
   localparam int TX_FIR_TAPS   = 97;

   // +1.0 in Q2.13
   localparam logic signed [15:0] Q13_ONE = 16'sd8192;

endpackage

// File: rtl/tx_sym_fifo.sv
// Small synchronous symbol FIFO. No fall-through: a word pushed this cycle
// becomes visible at the head on the next cycle.
module tx_sym_fifo #(
   parameter int DATA_WIDTH = 16,
   parameter int FIFO_DEPTH = 8,
   localparam int AW = $clog2(FIFO_DEPTH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] head,
   output logic                  full,
   output logic                  empty,
   output logic [AW:0]           count
);

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic                  do_push;
   logic                  do_pop;

   assign full    = (count == (AW+1)'(FIFO_DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   // Storage write; contents need no reset since count gates visibility.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/tx_frame_ctrl.sv
// Frame sequencer feeding the TX FIR: preamble, payload from the symbol
// FIFO, then a zero flush, with one load slot every UPSAMPLE cycles.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  IDLE     | waiting for start; filt_en low
//  PREAMBLE | alternating +/-PREAMBLE_AMP slots, PREAMBLE_LEN of them
//  PAYLOAD  | frame_len slots popped from the FIFO (0 on underrun)
//  FLUSH    | FLUSH_LEN zero cycles to drain the filter delay line
module tx_frame_ctrl
   import tx_pkg::*;
#(
   parameter int DATA_WIDTH   = TX_DATA_WIDTH,
   parameter int UPSAMPLE     = TX_UPSAMPLE,
   parameter int FLUSH_LEN    = TX_FIR_TAPS,
   parameter int PREAMBLE_LEN = 8,
   parameter logic signed [DATA_WIDTH-1:0] PREAMBLE_AMP = DATA_WIDTH'(Q13_ONE),
   parameter int FIFO_DEPTH   = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [15:0]           frame_len,
   input  logic [DATA_WIDTH-1:0] sym_data,
   input  logic                  sym_valid,
   output logic                  sym_ready,
   output logic [DATA_WIDTH-1:0] filt_data,
   output logic                  filt_en,
   output logic                  busy,
   output logic                  done,
   output logic                  underrun
);

   localparam int PH_W = (UPSAMPLE > 1) ? $clog2(UPSAMPLE) : 1;
   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam logic [PH_W-1:0] PH_LAST     = PH_W'(UPSAMPLE - 1);
   localparam logic [15:0]     PRE_LAST    = 16'(PREAMBLE_LEN - 1);
   localparam logic [15:0]     FLUSH_START = 16'(FLUSH_LEN - 1);

   tx_state_t             state_q, state_d;
   logic [PH_W-1:0]       phase_q, phase_d;
   logic [15:0]           slot_q, slot_d;
   logic [15:0]           flush_q, flush_d;
   logic [15:0]           len_q, len_d;
   logic [DATA_WIDTH-1:0] filt_data_d;
   logic                  filt_en_d, busy_d, done_d, underrun_d;
   logic                  load_payload;
   logic                  fifo_pop;
   logic [DATA_WIDTH-1:0] fifo_head;
   logic                  fifo_full, fifo_empty;
   logic [AW:0]           fifo_count;
   logic                  unused_fifo_count;

   assign sym_ready         = ~fifo_full;
   assign unused_fifo_count = ^fifo_count;

   tx_sym_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (sym_valid),
      .push_data (sym_data),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // Next state, counters and next-cycle outputs; outputs are registered so
   // everything here describes the cycle after the current one.
   always_comb begin
      state_d      = state_q;
      phase_d      = phase_q;
      slot_d       = slot_q;
      flush_d      = flush_q;
      len_d        = len_q;
      filt_data_d  = '0;
      filt_en_d    = filt_en;
      busy_d       = busy;
      done_d       = 1'b0;
      underrun_d   = underrun;
      load_payload = 1'b0;
      fifo_pop     = 1'b0;

      if (state_q != IDLE) begin
         phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d     = PREAMBLE;
               phase_d     = '0;
               slot_d      = '0;
               len_d       = frame_len;
               filt_en_d   = 1'b1;
               busy_d      = 1'b1;
               underrun_d  = 1'b0;
               filt_data_d = PREAMBLE_AMP;
            end
         end
         PREAMBLE: begin
            if (phase_q == PH_LAST) begin
               if (slot_q == PRE_LAST) begin
                  slot_d = '0;
                  if (len_q == '0) begin
                     state_d = FLUSH;
                     flush_d = FLUSH_START;
                  end else begin
                     state_d      = PAYLOAD;
                     load_payload = 1'b1;
                  end
               end else begin
                  // next slot index has the opposite parity of slot_q
                  slot_d      = slot_q + 16'd1;
                  filt_data_d = slot_q[0] ? PREAMBLE_AMP : -PREAMBLE_AMP;
               end
            end
         end
         PAYLOAD: begin
            if (phase_q == PH_LAST) begin
               if (slot_q == len_q - 16'd1) begin
                  state_d = FLUSH;
                  flush_d = FLUSH_START;
               end else begin
                  slot_d       = slot_q + 16'd1;
                  load_payload = 1'b1;
               end
            end
         end
         FLUSH: begin
            if (flush_q == '0) begin
               state_d   = IDLE;
               filt_en_d = 1'b0;
               busy_d    = 1'b0;
               done_d    = 1'b1;
            end else begin
               flush_d = flush_q - 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      // The head is popped on the edge that presents it, so a symbol pushed
      // on that same edge into an empty FIFO is too late for this slot.
      if (load_payload) begin
         if (fifo_empty) begin
            underrun_d = 1'b1;
         end else begin
            fifo_pop    = 1'b1;
            filt_data_d = fifo_head;
         end
      end
   end

   // State, counter and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         phase_q   <= '0;
         slot_q    <= '0;
         flush_q   <= '0;
         len_q     <= '0;
         filt_data <= '0;
         filt_en   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         underrun  <= 1'b0;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         slot_q    <= slot_d;
         flush_q   <= flush_d;
         len_q     <= len_d;
         filt_data <= filt_data_d;
         filt_en   <= filt_en_d;
         busy      <= busy_d;
         done      <= done_d;
         underrun  <= underrun_d;
      end
   end

endmodule

// File: doc/tx_frame_ctrl.md
# tx_frame_ctrl

Frame sequencer for the transmit pulse-shaping filter. It accepts modulator symbols through a valid/ready handshake and buffers them in a small FIFO. On a `start` pulse it drives the filter's `read_ready`/`data_in` pair so each symbol lands on the filter's load phase: first a fixed preamble, then `frame_len` payload symbols, then a zero flush that drains the filter's delay line. It sits between the modulator and the 97-tap TX FIR.

## Interface
- `DATA_WIDTH`, 16: symbol/sample width, signed Q2.13.
- `UPSAMPLE`, 6: filter load period in clk cycles; must equal the filter's internal zero-stuff period.
- `FLUSH_LEN`, 97: zero-sample cycles after the last symbol slot; equals the filter tap count.
- `PREAMBLE_LEN`, 8: number of preamble symbols.
- `PREAMBLE_AMP`, 16'sd8192: preamble magnitude (+1.0 in Q2.13).
- `FIFO_DEPTH`, 8: symbol FIFO entries, power of two.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  single-cycle frame request; ignored while `busy`.
- `frame_len`  in  16  payload symbol count, sampled on an accepted `start`.
- `sym_data`  in  DATA_WIDTH  symbol from the modulator.
- `sym_valid`  in  1  `sym_data` is valid.
- `sym_ready`  out  1  FIFO not full.
- `filt_data`  out  DATA_WIDTH  to the filter's `data_in`.
- `filt_en`  out  1  to the filter's `read_ready`.
- `busy`  out  1  frame in progress (any state except IDLE).
- `done`  out  1  one-cycle pulse at frame end.
- `underrun`  out  1  sticky; set when a payload slot finds the FIFO empty; cleared on an accepted `start` or on reset.

## Operation
- FIFO push on `sym_valid && sym_ready` in every state, including IDLE, so the FIFO can be prefilled.
- FIFO pop only at payload slots. The FIFO has no fall-through: a push and a pop to an empty FIFO in the same cycle counts as empty.
- States:
  - IDLE: waits for `start`.
  - PREAMBLE: `PREAMBLE_LEN` slots.
  - PAYLOAD: `frame_len` slots.
  - FLUSH: `FLUSH_LEN` cycles.
  - Then back to IDLE.
- Transitions:
  - IDLE→PREAMBLE on `start`.
  - PREAMBLE→PAYLOAD after the last preamble slot.
  - If `frame_len`==0, PREAMBLE→FLUSH directly.
  - PAYLOAD→FLUSH after the last payload slot.
  - FLUSH→IDLE after `FLUSH_LEN` cycles.
- Phase counter runs 0..UPSAMPLE-1 while `filt_en`=1. A slot is phase 0; the first `filt_en` cycle is phase 0.
- Slot data:
  - Preamble slot k: +`PREAMBLE_AMP` for even k, −`PREAMBLE_AMP` for odd k.
  - Payload slot: FIFO head, popped that cycle. If the FIFO is empty, drive 0, set `underrun`; the slot still counts.
- Non-slot cycles and all FLUSH cycles drive `filt_data`=0.
- `filt_en` stays continuously high from the first preamble slot to the last flush cycle. It never toggles mid-frame, because a low cycle would reset the filter's phase counter.
- Symbol and flush counters are 16 bits; no wrap is possible within one frame.
- Reset, including mid-frame:
  - State returns to IDLE and the FIFO is emptied.
  - `filt_en`, `filt_data`, `busy`, `done` and `underrun` go to 0.
  - `sym_ready` is 1 from the first cycle after reset.

## Timing
- All outputs are registered except `sym_ready`, which is the registered-count not-full flag.
- `start` accepted in cycle t: `busy`=1, `filt_en`=1 and `filt_data`=+`PREAMBLE_AMP` in cycle t+1.
- Slot n (0-based, counting preamble slots and payload slots together) appears in cycle t+1+n·UPSAMPLE.
- `filt_en` is high for exactly (PREAMBLE_LEN+frame_len)·UPSAMPLE+FLUSH_LEN cycles.
- In the first cycle with `filt_en`=0, `done`=1 and `busy`=0.
- A `start` in that same cycle is accepted; the next frame begins the cycle after.
- `start` while `busy` is ignored and `frame_len` is not resampled.

## Structure
- Package `tx_pkg`:
  - state enum `tx_state_t` {IDLE, PREAMBLE, PAYLOAD, FLUSH}
  - `TX_DATA_WIDTH`=16, `TX_UPSAMPLE`=6, `TX_FIR_TAPS`=97
  - Q2.13 constant `Q13_ONE`=8192
- Sub-module `tx_sym_fifo`: synchronous FIFO (DATA_WIDTH, FIFO_DEPTH) with push, pop, head, full, empty and count outputs.
- FSM, phase counter and slot counters live in `tx_frame_ctrl`.

## Test plan
- **Prefilled frame.** UPSAMPLE=6, PREAMBLE_LEN=4, FIFO prefilled with 100, 200; `start` with `frame_len`=2.
  - `filt_data` slots: 8192, −8192, 8192, −8192, 100, 200 at cycles t+1, +7, +13, +19, +25, +31; zeros elsewhere.
  - `filt_en` high for 133 cycles, then `done` for 1 cycle.
- **Underrun.** Same config, FIFO empty, `frame_len`=2.
  - Payload slots drive 0; `underrun`=1 from cycle t+25 until the next accepted `start`.
- **Zero-length frame.** `frame_len`=0.
  - 4 preamble slots, then flush; `filt_en` high for 24+97=121 cycles.
- **Full FIFO backpressure.** Push 9 symbols with the FIFO idle.
  - `sym_ready`=0 after the 8th push; the 9th symbol is held until the first payload pop frees an entry.
- **Reset mid-frame.** Assert reset during PAYLOAD.
  - Next cycle: `filt_en`=0, `busy`=0, FIFO empty, `sym_ready`=1; a subsequent `start` produces a clean frame.
- **Start while busy.** `start` during FLUSH is ignored; `start` in the `done` cycle gives `filt_en`=1 in the next cycle.
